accumulator_alu: RTL and testbench

Parametrised, clocked accumulator ALU; successor to the combinational 8-bit ALU. Holds a WIDTH-bit accumulator and registered status flags (zero, negative, carry/borrow, signed overflow). Provides carry/borrow chaining (ADC/SBC) for multi-word arithmetic and a multi-cycle shift-add multiply. Sits between the TinyTapeout I/O decode and the datapath; operations enter through a valid/ready handshake.

---
 rtl/accumulator_alu.sv | 262 ++++++++++++++++++++++++++
 tb/tb_accumulator_alu.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/accumulator_alu.sv
// -----------------------------------------------------------------------------
// accumulator_alu
//
// Clocked accumulator ALU. It holds a WIDTH-bit accumulator and the registered
// status flags carry/borrow, zero, negative and signed overflow. Operations
// arrive through a valid/ready handshake and use the accumulator as operand A
// and operand_i as operand B.
//
// Most operations complete in a single cycle. MUL runs a WIDTH-step shift-add
// multiply, and op_ready_o is low while it runs.
//
// Ports
//   clk_i           clock; all state changes on the rising edge
//   rst_n_i         asynchronous, active-low reset
//   op_valid_i      operation request
//   op_ready_o      block can accept an operation this cycle
//   op_i            opcode (OP_WIDTH bits, fixed encoding below)
//   operand_i       operand B
//   acc_o           accumulator value
//   result_valid_o  one-cycle pulse: acc_o and the flags were just updated
//   carry_o         carry (ADD/ADC), borrow (SUB/SBC/CMP), shifted-out bit,
//                   or "high half non-zero" (MUL)
//   zero_o          result == 0
//   negative_o      result MSB
//   overflow_o      signed overflow of ADD/ADC/SUB/SBC/CMP
// -----------------------------------------------------------------------------
module accumulator_alu #(
    parameter int WIDTH    = 8,
    parameter int OP_WIDTH = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                op_valid_i,
    output logic                op_ready_o,
    input  logic [OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]    operand_i,
    output logic [WIDTH-1:0]    acc_o,
    output logic                result_valid_o,
    output logic                carry_o,
    output logic                zero_o,
    output logic                negative_o,
    output logic                overflow_o
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    localparam logic [OP_WIDTH-1:0] OP_LOAD = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_CLR  = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_NOT  = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_AND  = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_OR   = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_XOR  = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_ADD  = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ADC  = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_SUB  = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SBC  = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_SHL  = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_SHR  = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_MUL  = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_CMP  = OP_WIDTH'(14);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t                 state_q,    state_d;
    logic [WIDTH-1:0]       acc_q,      acc_d;
    logic                   carry_q,    carry_d;
    logic                   zero_q,     zero_d;
    logic                   negative_q, negative_d;
    logic                   overflow_q, overflow_d;
    logic                   valid_q,    valid_d;
    logic [2*WIDTH-1:0]     mcand_q,    mcand_d;
    logic [WIDTH-1:0]       mplier_q,   mplier_d;
    logic [2*WIDTH-1:0]     prod_q,     prod_d;
    logic [CNT_W-1:0]       count_q,    count_d;

    logic                   accept;
    logic                   add_cin;
    logic                   sub_bin;
    logic [WIDTH:0]         add_sum;
    logic [WIDTH:0]         sub_diff;
    logic                   add_ovf;
    logic                   sub_ovf;
    logic [2*WIDTH-1:0]     step_prod;

    assign accept = op_valid_i && (state_q == ST_IDLE);

    // Both adders always see the current accumulator; only ADC/SBC feed the
    // stored carry back in.
    assign add_cin  = (op_i == OP_ADC) ? carry_q : 1'b0;
    assign sub_bin  = (op_i == OP_SBC) ? carry_q : 1'b0;
    assign add_sum  = {1'b0, acc_q} + {1'b0, operand_i} + (WIDTH+1)'(add_cin);
    // A negative W+1-bit difference sets bit WIDTH, which is exactly the borrow.
    assign sub_diff = {1'b0, acc_q} - {1'b0, operand_i} - (WIDTH+1)'(sub_bin);
    assign add_ovf  = (acc_q[WIDTH-1] == operand_i[WIDTH-1]) &&
                      (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
    assign sub_ovf  = (acc_q[WIDTH-1] != operand_i[WIDTH-1]) &&
                      (sub_diff[WIDTH-1] != acc_q[WIDTH-1]);

    // One shift-add step: the multiplicand walks left, the multiplier walks
    // right, and its LSB decides whether the multiplicand is added this step.
    assign step_prod = prod_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        logic [WIDTH-1:0] res;
        logic             write_acc;
        logic             upd_zn;

        state_d    = state_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        zero_d     = zero_q;
        negative_d = negative_q;
        overflow_d = overflow_q;
        valid_d    = 1'b0;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        prod_d     = prod_q;
        count_d    = count_q;
        res        = acc_q;
        write_acc  = 1'b0;
        upd_zn     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    valid_d = 1'b1;
                    case (op_i)
                        OP_LOAD: begin
                            res = operand_i; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_CLR: begin
                            res = '0; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_NOT: begin
                            res = ~acc_q; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_AND: begin
                            res = acc_q & operand_i; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_OR: begin
                            res = acc_q | operand_i; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_XOR: begin
                            res = acc_q ^ operand_i; write_acc = 1'b1; upd_zn = 1'b1;
                            overflow_d = 1'b0;
                        end
                        OP_ADD, OP_ADC: begin
                            res = add_sum[WIDTH-1:0]; write_acc = 1'b1; upd_zn = 1'b1;
                            carry_d    = add_sum[WIDTH];
                            overflow_d = add_ovf;
                        end
                        OP_SUB, OP_SBC: begin
                            res = sub_diff[WIDTH-1:0]; write_acc = 1'b1; upd_zn = 1'b1;
                            carry_d    = sub_diff[WIDTH];
                            overflow_d = sub_ovf;
                        end
                        OP_CMP: begin
                            // Flags of acc - B; the accumulator is not written.
                            res = sub_diff[WIDTH-1:0]; upd_zn = 1'b1;
                            carry_d    = sub_diff[WIDTH];
                            overflow_d = sub_ovf;
                        end
                        OP_SHL: begin
                            res = {acc_q[WIDTH-2:0], 1'b0}; write_acc = 1'b1; upd_zn = 1'b1;
                            carry_d    = acc_q[WIDTH-1];
                            overflow_d = 1'b0;
                        end
                        OP_SHR: begin
                            res = {1'b0, acc_q[WIDTH-1:1]}; write_acc = 1'b1; upd_zn = 1'b1;
                            carry_d    = acc_q[0];
                            overflow_d = 1'b0;
                        end
                        OP_MUL: begin
                            // Result and its pulse come when the last step lands.
                            valid_d  = 1'b0;
                            state_d  = ST_MUL;
                            count_d  = '0;
                            mcand_d  = {{WIDTH{1'b0}}, acc_q};
                            mplier_d = operand_i;
                            prod_d   = '0;
                        end
                        default: begin
                            // NOP and opcode 15: pulse only.
                        end
                    endcase
                end
            end

            ST_MUL: begin
                prod_d   = step_prod;
                mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
                mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
                count_d  = count_q + 1'b1;
                if (count_q == LAST_STEP) begin
                    res        = step_prod[WIDTH-1:0];
                    write_acc  = 1'b1;
                    upd_zn     = 1'b1;
                    carry_d    = |step_prod[2*WIDTH-1:WIDTH];
                    overflow_d = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        if (write_acc) begin
            acc_d = res;
        end
        if (upd_zn) begin
            zero_d     = (res == '0);
            negative_d = res[WIDTH-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            carry_q    <= 1'b0;
            zero_q     <= 1'b0;
            negative_q <= 1'b0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            prod_q     <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            zero_q     <= zero_d;
            negative_q <= negative_d;
            overflow_q <= overflow_d;
            valid_q    <= valid_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            prod_q     <= prod_d;
            count_q    <= count_d;
        end
    end

    assign op_ready_o     = (state_q == ST_IDLE);
    assign acc_o          = acc_q;
    assign result_valid_o = valid_q;
    assign carry_o        = carry_q;
    assign zero_o         = zero_q;
    assign negative_o     = negative_q;
    assign overflow_o     = overflow_q;

endmodule

// File: tb/tb_accumulator_alu.sv
// -----------------------------------------------------------------------------
// tb_accumulator_alu
//
// Directed bench for accumulator_alu (WIDTH=8). A table of single-cycle
// operations is applied back-to-back with hand-computed accumulator and flag
// values, followed by hand-written MUL sequences and a reset during MUL.
// -----------------------------------------------------------------------------
module tb_accumulator_alu;

    localparam logic [3:0] NOP  = 4'd0;
    localparam logic [3:0] LOAD = 4'd1;
    localparam logic [3:0] CLR  = 4'd2;
    localparam logic [3:0] NOT_ = 4'd3;
    localparam logic [3:0] AND_ = 4'd4;
    localparam logic [3:0] OR_  = 4'd5;
    localparam logic [3:0] XOR_ = 4'd6;
    localparam logic [3:0] ADD  = 4'd7;
    localparam logic [3:0] ADC  = 4'd8;
    localparam logic [3:0] SUB  = 4'd9;
    localparam logic [3:0] SBC  = 4'd10;
    localparam logic [3:0] SHL  = 4'd11;
    localparam logic [3:0] SHR  = 4'd12;
    localparam logic [3:0] MUL  = 4'd13;
    localparam logic [3:0] CMP  = 4'd14;
    localparam logic [3:0] OP15 = 4'd15;

    logic       clk;
    logic       rst_n;
    logic       op_valid;
    logic       op_ready;
    logic [3:0] op_code;
    logic [7:0] operand;
    logic [7:0] acc;
    logic       result_valid;
    logic       carry, zero, negative, overflow;

    accumulator_alu #(.WIDTH(8), .OP_WIDTH(4)) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .op_valid_i     (op_valid),
        .op_ready_o     (op_ready),
        .op_i           (op_code),
        .operand_i      (operand),
        .acc_o          (acc),
        .result_valid_o (result_valid),
        .carry_o        (carry),
        .zero_o         (zero),
        .negative_o     (negative),
        .overflow_o     (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0] op;
        logic [7:0] b;
        logic [7:0] acc;
        logic       c, z, n, v;
    } vec_t;

    vec_t vecs[40];
    int   nvec = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add_vec(input logic [3:0] op, input logic [7:0] b, input logic [7:0] a,
                           input logic c, input logic z, input logic n, input logic v);
        vecs[nvec].op  = op;
        vecs[nvec].b   = b;
        vecs[nvec].acc = a;
        vecs[nvec].c   = c;
        vecs[nvec].z   = z;
        vecs[nvec].n   = n;
        vecs[nvec].v   = v;
        nvec++;
    endtask

    function automatic int pack(input logic [7:0] a, input logic c, input logic z,
                                input logic n, input logic v);
        return int'({a, c, z, n, v});
    endfunction

    function automatic int dut_state();
        return pack(acc, carry, zero, negative, overflow);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Present an operation at the falling edge and return 1 ns after the
    // rising edge that accepts it; op_valid is left asserted.
    task automatic apply(input logic [3:0] op, input logic [7:0] b);
        @(negedge clk);
        op_valid = 1'b1;
        op_code  = op;
        operand  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_op(input logic [3:0] op, input logic [7:0] b);
        apply(op, b);
        op_valid = 1'b0;
        $display("op %0d b %0d -> acc %0d c%0d z%0d n%0d v%0d rv%0d",
                 op, b, acc, carry, zero, negative, overflow, result_valid);
    endtask

    // Wait (bounded) for the MUL result pulse, checking that the block stays
    // busy and the visible state holds still until then.
    task automatic wait_mul(input string name, input int hold_state, output int cycles);
        int bad_hold;
        logic got;
        bad_hold = 0;
        got      = 1'b0;
        cycles   = 0;
        while (cycles < 20 && !got) begin
            @(posedge clk);
            #1;
            cycles++;
            if (result_valid) got = 1'b1;
            else if (op_ready || dut_state() != hold_state) bad_hold++;
        end
        chk({name, " latency"}, cycles, 8);
        chk({name, " busy/hold"}, bad_hold, 0);
    endtask

    initial begin
        int cycles;
        int pulses;
        int snap;

        rst_n    = 1'b0;
        op_valid = 1'b0;
        op_code  = NOP;
        operand  = 8'd0;

        // acc, c, z, n, v after each operation, applied back-to-back
        add_vec(NOP,  8'd0,   8'd0,   0, 0, 0, 0);
        add_vec(LOAD, 8'd200, 8'd200, 0, 0, 1, 0);
        add_vec(ADD,  8'd150, 8'd94,  1, 0, 0, 1);
        add_vec(ADC,  8'd0,   8'd95,  0, 0, 0, 0);
        add_vec(LOAD, 8'h7F,  8'h7F,  0, 0, 0, 0);
        add_vec(ADD,  8'd1,   8'h80,  0, 0, 1, 1);
        add_vec(LOAD, 8'd5,   8'd5,   0, 0, 0, 0);
        add_vec(SUB,  8'd10,  8'd251, 1, 0, 1, 0);
        add_vec(SBC,  8'd0,   8'd250, 0, 0, 1, 0);
        add_vec(LOAD, 8'd255, 8'd255, 0, 0, 1, 0);
        add_vec(SUB,  8'd255, 8'd0,   0, 1, 0, 0);
        add_vec(LOAD, 8'd5,   8'd5,   0, 0, 0, 0);
        add_vec(CMP,  8'd5,   8'd5,   0, 1, 0, 0);
        add_vec(CMP,  8'd6,   8'd5,   1, 0, 1, 0);
        add_vec(LOAD, 8'h81,  8'h81,  1, 0, 1, 0);
        add_vec(SHL,  8'd0,   8'h02,  1, 0, 0, 0);
        add_vec(SHR,  8'd0,   8'h01,  0, 0, 0, 0);
        add_vec(LOAD, 8'h80,  8'h80,  0, 0, 1, 0);
        add_vec(SHL,  8'd0,   8'h00,  1, 1, 0, 0);
        add_vec(LOAD, 8'hAA,  8'hAA,  1, 0, 1, 0);
        add_vec(AND_, 8'h55,  8'h00,  1, 1, 0, 0);
        add_vec(LOAD, 8'hAA,  8'hAA,  1, 0, 1, 0);
        add_vec(OR_,  8'h55,  8'hFF,  1, 0, 1, 0);
        add_vec(XOR_, 8'hAA,  8'h55,  1, 0, 0, 0);
        add_vec(NOT_, 8'h00,  8'hAA,  1, 0, 1, 0);
        add_vec(CLR,  8'h00,  8'h00,  1, 1, 0, 0);
        add_vec(LOAD, 8'h7F,  8'h7F,  1, 0, 0, 0);
        add_vec(ADC,  8'h00,  8'h80,  0, 0, 1, 1);
        add_vec(OP15, 8'h12,  8'h80,  0, 0, 1, 1);
        add_vec(NOP,  8'h34,  8'h80,  0, 0, 1, 1);
        add_vec(AND_, 8'hFF,  8'h80,  0, 0, 1, 0);
        add_vec(LOAD, 8'h80,  8'h80,  0, 0, 1, 0);
        add_vec(SBC,  8'h01,  8'h7F,  0, 0, 0, 1);

        // Reset state
        #12;
        chk("reset flags/acc", dut_state(), 0);
        chk("reset ready", int'(op_ready), 1);
        chk("reset result_valid", int'(result_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("idle result_valid", int'(result_valid), 0);

        // Single-cycle table, one accepted op per cycle
        for (int i = 0; i < nvec; i++) begin
            apply(vecs[i].op, vecs[i].b);
            $display("vec %0d op %0d b 0x%02h -> acc 0x%02h c%0d z%0d n%0d v%0d rv%0d",
                     i, vecs[i].op, vecs[i].b, acc, carry, zero, negative, overflow, result_valid);
            chk($sformatf("vec%0d state", i), dut_state(),
                pack(vecs[i].acc, vecs[i].c, vecs[i].z, vecs[i].n, vecs[i].v));
            chk($sformatf("vec%0d result_valid", i), int'(result_valid), 1);
        end
        @(negedge clk);
        op_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pulse ends after table", int'(result_valid), 0);

        // MUL 13 * 11 = 143
        do_op(LOAD, 8'd13);
        snap = dut_state();
        apply(MUL, 8'd11);
        op_valid = 1'b0;
        chk("mul1 ready after accept", int'(op_ready), 0);
        chk("mul1 no early pulse", int'(result_valid), 0);
        wait_mul("mul1", snap, cycles);
        $display("mul 13*11 -> acc %0d c%0d z%0d n%0d v%0d after %0d cycles",
                 acc, carry, zero, negative, overflow, cycles);
        chk("mul1 result", dut_state(), pack(8'd143, 0, 0, 1, 0));
        chk("mul1 ready on pulse", int'(op_ready), 1);
        @(posedge clk);
        #1;
        chk("mul1 single pulse", int'(result_valid), 0);

        // MUL 16 * 16 = 256 with a LOAD 99 request held throughout
        do_op(LOAD, 8'd16);
        snap = dut_state();
        apply(MUL, 8'd16);
        op_code = LOAD;
        operand = 8'd99;
        wait_mul("mul2", snap, cycles);
        $display("mul 16*16 -> acc %0d c%0d z%0d n%0d v%0d after %0d cycles",
                 acc, carry, zero, negative, overflow, cycles);
        chk("mul2 result", dut_state(), pack(8'd0, 1, 1, 0, 0));
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        $display("held LOAD 99 -> acc %0d rv%0d", acc, result_valid);
        chk("held load accepted", dut_state(), pack(8'd99, 1, 0, 0, 0));
        chk("held load pulse", int'(result_valid), 1);
        @(posedge clk);
        #1;
        chk("held load single pulse", int'(result_valid), 0);

        // Reset in the middle of a MUL
        do_op(LOAD, 8'd3);
        apply(MUL, 8'd5);
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        $display("reset mid-MUL -> acc %0d ready %0d rv%0d", acc, op_ready, result_valid);
        chk("midmul reset state", dut_state(), 0);
        chk("midmul reset ready", int'(op_ready), 1);
        chk("midmul reset rv", int'(result_valid), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (result_valid) pulses++;
        end
        chk("midmul no stray pulse", pulses, 0);
        chk("midmul state after release", dut_state(), 0);
        chk("midmul ready after release", int'(op_ready), 1);
        do_op(LOAD, 8'd7);
        chk("load after reset", dut_state(), pack(8'd7, 0, 0, 0, 0));
        chk("load after reset pulse", int'(result_valid), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
